// File: rtl/tdm_demux_8.sv
// Receive-side 1-to-8 TDM demultiplexer: counts slots, rebuilds an MSB-first byte per frame
// and offers each completed frame on a valid/ready port with overrun and sync-error pulses.
module tdm_demux_8 #(
  parameter int SYNC_REQUIRED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       sync,
  input  logic       din,
  output logic [2:0] slot,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       overrun,
  output logic       sync_err
);

  localparam logic [0:0] HUNT      = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam bit         SYNC_EN   = (SYNC_REQUIRED != 0);
  localparam logic [0:0] RST_STATE = SYNC_EN ? HUNT : RUN;

  logic [0:0] state_p0;
  logic [7:0] shift_p0;
  logic [7:0] word_p0;
  logic       sync_use;
  logic       start;
  logic       resync;
  logic       advance;
  logic       complete;
  logic       accept;

  // Slot k lands in bit 7-k so the first bit on the wire becomes the MSB.
  function automatic logic [7:0] put_bit(input logic [7:0] s, input logic [2:0] k,
                                         input logic b);
    logic [7:0] r;
    r = s;
    r[3'd7 - k] = b;
    return r;
  endfunction

  assign sync_use = SYNC_EN && sync;
  assign start    = bit_en && (state_p0 == HUNT) && sync_use;
  assign resync   = bit_en && (state_p0 == RUN) && sync_use && (slot != 3'd0);
  assign advance  = bit_en && (state_p0 == RUN) && !resync;
  assign complete = advance && (slot == 3'd7);
  assign accept   = dout_valid && dout_ready;
  assign word_p0  = {shift_p0[7:1], din};

  // Stage p0 -> output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0   <= RST_STATE;
      slot       <= 3'd0;
      shift_p0   <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      sync_err <= 1'b0;

      if (start) begin
        shift_p0 <= {din, 7'b0};
        slot     <= 3'd1;
        state_p0 <= RUN;
      end else if (resync) begin
        // Misplaced marker: the partial frame is dropped and this bit restarts at slot 0.
        shift_p0 <= {din, 7'b0};
        slot     <= 3'd1;
        sync_err <= 1'b1;
      end else if (advance) begin
        shift_p0 <= put_bit(shift_p0, slot, din);
        slot     <= slot + 3'd1;
      end

      if (complete) begin
        dout       <= word_p0;
        dout_valid <= 1'b1;
        overrun    <= dout_valid && !dout_ready;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8: a vector table for framing/resync plus hand sequences
// for strobe spacing, overrun, coincident accept, async reset and free-running mode.
module tb_tdm_demux_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0, sync = 1'b0, din = 1'b0, dout_ready = 1'b0;
  logic [2:0] slot;
  logic [7:0] dout;
  logic       dout_valid, overrun, sync_err;

  logic       en_f = 1'b0, sync_f = 1'b0, din_f = 1'b0, ready_f = 1'b0;
  logic [2:0] slot_f;
  logic [7:0] dout_f;
  logic       valid_f, ovr_f, serr_f;

  int n_checks = 0;
  int n_err = 0;

  tdm_demux_8 #(.SYNC_REQUIRED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sync(sync), .din(din),
    .slot(slot), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .sync_err(sync_err)
  );

  tdm_demux_8 #(.SYNC_REQUIRED(0)) u_free (
    .clk(clk), .rst_n(rst_n), .bit_en(en_f), .sync(sync_f), .din(din_f),
    .slot(slot_f), .dout(dout_f), .dout_valid(valid_f), .dout_ready(ready_f),
    .overrun(ovr_f), .sync_err(serr_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         en, sy, d, r;
    logic [2:0] slot;
    logic [7:0] dout;
    bit         v, o, e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(bit en, bit sy, bit d, bit r, logic [2:0] s, logic [7:0] w,
                               bit v, bit o, bit e);
    vec_t x;
    x.en = en; x.sy = sy; x.d = d; x.r = r;
    x.slot = s; x.dout = w; x.v = v; x.o = o; x.e = e;
    return x;
  endfunction

  function automatic logic [13:0] mk(logic [2:0] s, logic [7:0] w, bit v, bit o, bit e);
    return {s, w, v, o, e};
  endfunction

  function automatic logic [13:0] st_main();
    return {slot, dout, dout_valid, overrun, sync_err};
  endfunction

  function automatic logic [13:0] st_free();
    return {slot_f, dout_f, valid_f, ovr_f, serr_f};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual slot=%0d dout=%h v=%b o=%b e=%b required slot=%0d dout=%h v=%b o=%b e=%b",
               name, act[13:11], act[10:3], act[2], act[1], act[0],
               exp[13:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input bit en, input bit s, input bit d, input bit r);
    bit_en = en; sync = s; din = d; dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input bit r_body, input bit r_last);
    for (int k = 0; k < 8; k++)
      step(1'b1, k == 0, w[7-k], (k == 7) ? r_last : r_body);
  endtask

  initial begin
    logic [7:0] w;

    // Framing and resync vectors, starting from reset in HUNT
    tbl.push_back(mkv(1,1,1,1, 3'd1, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd2, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd3, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd4, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd5, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd6, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd7, 8'h00, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd0, 8'hA5, 1,0,0));
    tbl.push_back(mkv(0,0,0,1, 3'd0, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,1,1,1, 3'd1, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd2, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd3, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd4, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,1,1,1, 3'd1, 8'hA5, 0,0,1));
    tbl.push_back(mkv(1,0,1,1, 3'd2, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd3, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,1,1, 3'd4, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd5, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd6, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd7, 8'hA5, 0,0,0));
    tbl.push_back(mkv(1,0,0,1, 3'd0, 8'hF0, 1,0,0));
    tbl.push_back(mkv(0,0,0,1, 3'd0, 8'hF0, 0,0,0));

    #12;
    chk("reset_main", st_main(), mk(3'd0, 8'h00, 0,0,0));
    chk("reset_free", st_free(), mk(3'd0, 8'h00, 0,0,0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sy, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d", i), st_main(),
          mk(tbl[i].slot, tbl[i].dout, tbl[i].v, tbl[i].o, tbl[i].e));
    end

    // Strobe every third clock; din toggles on idle cycles and must be ignored
    w = 8'hC1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, w[7-k], 1'b1);
      if (k < 7) begin
        chk("sparse_strobe", st_main(), mk(3'(k+1), 8'hF0, 0,0,0));
        step(1'b0, 1'b1, ~w[7-k], 1'b1);
        chk("sparse_idle1", st_main(), mk(3'(k+1), 8'hF0, 0,0,0));
        step(1'b0, 1'b0, ~w[7-k], 1'b1);
        chk("sparse_idle2", st_main(), mk(3'(k+1), 8'hF0, 0,0,0));
      end else begin
        chk("sparse_done", st_main(), mk(3'd0, 8'hC1, 1,0,0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sparse_acc", st_main(), mk(3'd0, 8'hC1, 0,0,0));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("sparse_hold", st_main(), mk(3'd0, 8'hC1, 0,0,0));
      end
    end

    // Back-to-back frames with no consumer: overrun
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ovr_first", st_main(), mk(3'd0, 8'h3C, 1,0,0));
    w = 8'h81;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, w[7-k], 1'b0);
      if (k == 3) chk("ovr_mid", st_main(), mk(3'd4, 8'h3C, 1,0,0));
    end
    chk("ovr_pulse", st_main(), mk(3'd0, 8'h81, 1,1,0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_once", st_main(), mk(3'd0, 8'h81, 1,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_accept", st_main(), mk(3'd0, 8'h81, 0,0,0));

    // Acceptance coincident with a completion: new word, valid stays, no overrun
    send_frame(8'h69, 1'b0, 1'b0);
    chk("coin_first", st_main(), mk(3'd0, 8'h69, 1,0,0));
    send_frame(8'h96, 1'b0, 1'b1);
    chk("coin_load", st_main(), mk(3'd0, 8'h96, 1,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("coin_hold", st_main(), mk(3'd0, 8'h96, 1,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("coin_accept", st_main(), mk(3'd0, 8'h96, 0,0,0));

    // Asynchronous reset mid-frame with a pending word
    send_frame(8'h11, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, 1'b0);
    chk("pre_reset", st_main(), mk(3'd5, 8'h11, 1,0,0));
    rst_n = 1'b0;
    #2;
    chk("async_reset", st_main(), mk(3'd0, 8'h00, 0,0,0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("post_reset", st_main(), mk(3'd0, 8'h5A, 1,0,0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_accept", st_main(), mk(3'd0, 8'h5A, 0,0,0));

    // Unsynchronised stream: main stays in HUNT, free-running instance frames anyway
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      en_f = 1'b1; din_f = w[7-k]; sync_f = (k == 3);
      step(1'b1, 1'b0, w[7-k], 1'b1);
      chk("hunt_hold", st_main(), mk(3'd0, 8'h00, 0,0,0));
      if (k == 3) chk("free_mid", st_free(), mk(3'd4, 8'h00, 0,0,0));
    end
    chk("free_word", st_free(), mk(3'd0, 8'hB4, 1,0,0));
    en_f = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("hunt_more", st_main(), mk(3'd0, 8'h00, 0,0,0));
    chk("free_idle", st_free(), mk(3'd0, 8'hB4, 1,0,0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
